// File: rtl/strip_trigger_pkg.sv
// Shared types for the strip trigger load path: candidate layout and scheduler states.
// Pure declarations; no timing or flow-control behaviour of its own.
package strip_trigger_pkg;

   localparam int BCID_W = 12;
   localparam int BAND_W = 8;

   typedef struct packed {
      logic [BCID_W-1:0] bcid;
      logic [BAND_W-1:0] band_id;
   } cand_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/trig_cand_fifo.sv
// Register-array FIFO for trigger candidates; level/full/empty update at the push/pop edge.
// Push when full is accepted only alongside a pop; flush overrides push and pop.
module trig_cand_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 20
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[head];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         level <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         level <= '0;
      end else begin
         if (do_push) tail <= tail + AW'(1);
         if (do_pop)  head <= head + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

   // Storage carries no reset; only head/tail/level define validity.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[tail] <= wdata;
   end

endmodule

// File: rtl/strip_trigger_load_scheduler.sv
// Queues strip-trigger candidates and issues one registered load per eligible 160 MHz slot.
// Issue waits for slot && enable && gen_ready and the minimum slot gap; queue keeps filling meanwhile.
module strip_trigger_load_scheduler
   import strip_trigger_pkg::*;
#(
   parameter int SLOT_DIV      = 4,
   parameter int DEPTH         = 8,
   parameter int MIN_GAP_SLOTS = 1,
   parameter int BCID_W        = strip_trigger_pkg::BCID_W,
   parameter int BAND_W        = strip_trigger_pkg::BAND_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cand_valid,
   input  logic [BCID_W-1:0]      cand_bcid,
   input  logic [BAND_W-1:0]      cand_band_id,
   input  logic                   gen_ready,
   input  logic                   enable,
   input  logic                   flush,
   input  logic                   clear_stats,
   output logic                   load,
   output logic [BCID_W-1:0]      load_bcid,
   output logic [BAND_W-1:0]      load_band_id,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [15:0]            drop_count,
   output logic [15:0]            dup_count,
   output logic                   overflow
);

   localparam int PH_W  = $clog2(SLOT_DIV);
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int GAP_W = $clog2(MIN_GAP_SLOTS) + 1;
   localparam int CW    = BCID_W + BAND_W;

   logic [PH_W-1:0]  slot_phase;
   logic             slot;
   sched_state_t     state, state_nx;
   logic [GAP_W-1:0] gap_cnt, gap_nx;
   logic [CW-1:0]    cand_pair, last_pair, head_pair;
   logic             last_valid;
   logic             full, empty;
   logic             is_dup, push_req, push, drop, issue;

   assign slot      = (slot_phase == PH_W'(SLOT_DIV - 1));
   assign cand_pair = {cand_bcid, cand_band_id};
   assign is_dup    = cand_valid && last_valid && (cand_pair == last_pair);
   assign issue     = (state == ST_WAIT) && slot && enable && gen_ready && !flush && !empty;
   assign push_req  = cand_valid && !is_dup && !flush;
   assign drop      = push_req && full && !issue;
   assign push      = push_req && !drop;

   trig_cand_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (issue),
      .flush   (flush),
      .wdata   (cand_pair),
      .rdata   (head_pair),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   always_comb begin
      state_nx = state;
      gap_nx   = gap_cnt;
      case (state)
         ST_IDLE: if (push) state_nx = ST_WAIT;
         ST_WAIT: begin
            if (issue) begin
               if (MIN_GAP_SLOTS > 1) begin
                  state_nx = ST_GAP;
                  gap_nx   = GAP_W'(MIN_GAP_SLOTS - 1);
               end else begin
                  state_nx = (fifo_level > LVL_W'(1) || push) ? ST_WAIT : ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (slot) begin
               if (gap_cnt <= GAP_W'(1)) begin
                  gap_nx   = '0;
                  state_nx = (!empty || push) ? ST_WAIT : ST_IDLE;
               end else begin
                  gap_nx = gap_cnt - GAP_W'(1);
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (flush) begin
         state_nx = ST_IDLE;
         gap_nx   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         slot_phase   <= '0;
         state        <= ST_IDLE;
         gap_cnt      <= '0;
         last_pair    <= '0;
         last_valid   <= 1'b0;
         load         <= 1'b0;
         load_bcid    <= '0;
         load_band_id <= '0;
      end else begin
         slot_phase <= slot_phase + PH_W'(1);
         state      <= state_nx;
         gap_cnt    <= gap_nx;
         load       <= issue;
         if (issue) {load_bcid, load_band_id} <= head_pair;
         // Dedup tracks the last pair that actually entered the queue.
         if (flush) begin
            last_valid <= 1'b0;
         end else if (push) begin
            last_pair  <= cand_pair;
            last_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || clear_stats) begin
         drop_count <= '0;
         dup_count  <= '0;
         overflow   <= 1'b0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
         if (is_dup && dup_count != 16'hFFFF) dup_count <= dup_count + 16'd1;
      end
   end

endmodule

// File: doc/strip_trigger_load_scheduler.md
# strip_trigger_load_scheduler

Queues strip-trigger candidates (BCID, band ID) from the logic-pad/band-ID stage and issues them to the strip trigger serializer one at a time. Issue happens only on the 160 MHz load slot (every SLOT_DIV-th clk), only while the serializer reports ready, and never closer together than MIN_GAP_SLOTS slots. The block replaces the free-running slot counter and load register in front of `strip_trigger_gen`. It adds buffering, de-duplication, flush and drop statistics.

## Interface
- SLOT_DIV, 4, clk cycles per load slot (power of two, ≥2)
- DEPTH, 8, candidate FIFO entries (power of two)
- MIN_GAP_SLOTS, 1, minimum slots from one load to the next (≥1)
- BCID_W, 12, BCID width
- BAND_W, 8, band ID width
- clk  in  1  system clock, single domain
- reset_n  in  1  synchronous, active-low reset
- cand_valid  in  1  one-cycle candidate strobe (data_ready_extend)
- cand_bcid  in  BCID_W  candidate BCID
- cand_band_id  in  BAND_W  candidate band ID
- gen_ready  in  1  serializer can accept a load
- enable  in  1  issue enable; the queue still fills when low
- flush  in  1  one-cycle request to empty the FIFO
- clear_stats  in  1  clears drop_count, dup_count and overflow
- load  out  1  one-cycle load pulse to the serializer
- load_bcid  out  BCID_W  BCID held with load; stable until the next load
- load_band_id  out  BAND_W  band ID held with load; stable until the next load
- fifo_level  out  log2(DEPTH)+1  current occupancy
- drop_count  out  16  saturating count of candidates dropped on full
- dup_count  out  16  saturating count of merged duplicates
- overflow  out  1  sticky; set on the first drop

## Operation
- slot_phase: free-running counter 0..SLOT_DIV-1; slot = (slot_phase == SLOT_DIV-1).
- Push: a cand_valid that is not a duplicate is written at the tail.
- Duplicate rule: the candidate's (bcid, band_id) equals the last accepted pair and last_valid=1. A duplicate is not pushed and dup_count increments.
- last_valid is cleared by reset and by flush.
- Full, no pop in the same cycle: the candidate is dropped, drop_count increments and overflow is set. Full with a pop in the same cycle: the push is accepted and level is unchanged.
- Counters saturate at 16'hFFFF. clear_stats zeroes the counters and overflow; an increment in the same cycle is lost, so clear wins.
- FSM states:
  - IDLE: FIFO empty.
  - WAIT: FIFO non-empty, waiting for the issue condition.
  - GAP: serving the minimum gap.
- Transitions:
  - IDLE→WAIT on push.
  - WAIT issues when slot && enable && gen_ready. The pop and the load register update happen at the same edge. Next state is GAP if MIN_GAP_SLOTS>1; otherwise WAIT if non-empty after the pop, else IDLE.
  - In GAP the gap counter decrements on each slot. At zero: WAIT if non-empty, else IDLE. No issue happens in GAP.
- flush: empties the FIFO (head=tail, level=0) and returns the FSM to IDLE. It has priority over a push and a pop in the same cycle; a pending issue that cycle is suppressed. Statistics are kept.
- gen_ready low or enable low in WAIT: hold; the entry stays at the head.

## Timing
- Reset (reset_n=0 at an edge): load=0, load_bcid=0, load_band_id=0, fifo_level=0, drop_count=0, dup_count=0, overflow=0, slot_phase=0, FSM=IDLE, last_valid=0.
- Reset mid-operation discards queued entries and any GAP.
- load is registered: high for exactly the one cycle after the issuing edge. load_bcid and load_band_id change only at that edge.
- Latency: a candidate pushed at edge k into an empty FIFO issues at the first slot edge ≥ k+1, provided gen_ready and enable. Minimum 1 clk, maximum SLOT_DIV clk.
- Loads are separated by ≥ MIN_GAP_SLOTS·SLOT_DIV clk.
- fifo_level updates at the same edge as the push, pop or flush.
- Sampled inputs are cand_valid, gen_ready, enable, flush and clear_stats, all at the rising edge. No combinational input-to-output paths.

## Structure
- Shared package `strip_trigger_pkg`:
  - BCID_W and BAND_W constants.
  - Candidate typedef {bcid, band_id}.
  - FSM state enum.
- Sub-module: `trig_cand_fifo`, a synchronous FIFO with full, empty, level and flush, built on a DEPTH-entry register array. Push and pop in the same cycle is legal when full or empty+push.
- The top level holds the slot counter, FSM, gap counter, dedup register and statistics.

## Test plan
- Defaults, one candidate (0x123, 0x05) pushed at slot_phase 1 with gen_ready=1 → load=1 two cycles later at phase 3 with those values; fifo_level 1→0.
- Three back-to-back candidates with MIN_GAP_SLOTS=2 → loads spaced by exactly 8 clk, in FIFO order.
- Nine distinct candidates with gen_ready=0 → fifo_level=8, drop_count=1, overflow=1. Raising gen_ready drains all 8 in order.
- Same (0x200, 0x10) twice, then (0x200, 0x11) → one queued entry plus a second entry, dup_count=1.
- FIFO at 5 entries, flush in the same cycle as a push and an issue slot → fifo_level=0, no load. The next candidate issues normally.
- Reset asserted during GAP with 3 queued → all outputs at their reset values. The first post-reset candidate issues within SLOT_DIV clk.
